tile_scheduler: RTL and testbench

Frame-level controller that sequences the 80x80 window loader across an image tiled into TILES_X x TILES_Y tiles. Per tile it:
- arms the loader;
- converts the loader's tile-local word row/col into a frame-memory read address;
- counts the 65x65 = 4225 16x16 windows presented to the correlator;
- advances to the next tile on the loader's done.

It sits between the frame-memory read port, the window loader and the top-level start/status logic.

---
 rtl/tile_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_tile_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// Frame-level tile sequencer for the 80x80 window loader: arms the loader per tile,
// maps tile-local word row/col to frame addresses and counts windows. Optional SCHED_WDOG_EN adds a stall watchdog.
module tile_scheduler #(
    parameter int TILES_X      = 8,
    parameter int TILES_Y      = 8,
    parameter int ADDR_W       = 16,
    parameter int WIN_PER_TILE = 4225,
    localparam int TX_W = (TILES_X > 1) ? $clog2(TILES_X) : 1,
    localparam int TY_W = (TILES_Y > 1) ? $clog2(TILES_Y) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              frame_done,
    output logic [TX_W-1:0]   tile_x,
    output logic [TY_W-1:0]   tile_y,
    output logic              wh_en,
    input  logic              wh_ack,
    input  logic [6:0]        wh_row,
    input  logic [6:0]        wh_col,
    input  logic              wh_window_ready,
    input  logic              wh_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [12:0]       win_count,
    output logic              err
`ifdef SCHED_WDOG_EN
    ,
    output logic              wdog_trip
`endif
);

    typedef enum logic [2:0] {IDLE, ARM, FILL, SCAN, NEXT, FIN} state_t;

    localparam logic [TX_W-1:0]   TX_LAST    = TX_W'(TILES_X - 1);
    localparam logic [TY_W-1:0]   TY_LAST    = TY_W'(TILES_Y - 1);
    localparam logic [12:0]       WIN_TARGET = 13'(WIN_PER_TILE);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(TILES_X * 20);

    state_t            state_q, state_d;
    logic [TX_W-1:0]   tile_x_q, tile_x_d;
    logic [TY_W-1:0]   tile_y_q, tile_y_d;
    logic [12:0]       win_count_q, win_count_d;
    logic              err_q, err_d;
    logic              busy_q, wh_en_q, mem_rd_q, frame_done_q;
    logic [12:0]       win_inc;
    logic [ADDR_W-1:0] frame_row, addr_calc;

`ifdef SCHED_WDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        wdog_trip_q, wdog_trip_d;
    logic        wdog_fire;
`endif

    assign win_inc = (win_count_q == 13'h1FFF) ? win_count_q : win_count_q + 13'd1;

    always_comb begin
        state_d     = state_q;
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        win_count_d = win_count_q;
        err_d       = err_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tile_x_d    = '0;
                        tile_y_d    = '0;
                        win_count_d = '0;
                        err_d       = 1'b0;
                        state_d     = ARM;
                    end
                end
                ARM: begin
                    if (wh_ack) state_d = FILL;
                end
                FILL: begin
                    // A done before any window means the loader gave up on this tile.
                    if (wh_done) begin
                        err_d   = 1'b1;
                        state_d = NEXT;
                    end else if (wh_window_ready) begin
                        win_count_d = 13'd1;
                        state_d     = SCAN;
                    end
                end
                SCAN: begin
                    if (wh_window_ready) win_count_d = win_inc;
                    if (wh_done) begin
                        if (win_count_d != WIN_TARGET) err_d = 1'b1;
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (tile_x_q == TX_LAST) begin
                        tile_x_d = '0;
                        if (tile_y_q == TY_LAST) begin
                            state_d = FIN;
                        end else begin
                            tile_y_d    = tile_y_q + 1'b1;
                            win_count_d = '0;
                            state_d     = ARM;
                        end
                    end else begin
                        tile_x_d    = tile_x_q + 1'b1;
                        win_count_d = '0;
                        state_d     = ARM;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
`ifdef SCHED_WDOG_EN
        if (wdog_fire) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

`ifdef SCHED_WDOG_EN
    assign wdog_fire = (state_q != IDLE) && (wdog_q == 16'hFFFF);

    // Any progress (state change or a window) proves the loader is alive.
    always_comb begin
        wdog_d      = wdog_q + 16'd1;
        wdog_trip_d = wdog_trip_q;
        if ((state_d != state_q) || wh_window_ready || (state_q == IDLE)) wdog_d = '0;
        if ((state_q == IDLE) && start && !abort) wdog_trip_d = 1'b0;
        if (wdog_fire) wdog_trip_d = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            win_count_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            wh_en_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SCHED_WDOG_EN
            wdog_q       <= '0;
            wdog_trip_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            win_count_q  <= win_count_d;
            err_q        <= err_d;
            busy_q       <= (state_d != IDLE);
            wh_en_q      <= (state_d == ARM);
            mem_rd_q     <= (state_d == ARM) || (state_d == FILL);
            frame_done_q <= (state_d == FIN);
`ifdef SCHED_WDOG_EN
            wdog_q       <= wdog_d;
            wdog_trip_q  <= wdog_trip_d;
`endif
        end
    end

    // Word address: frame row of the current tile times words per frame row, plus column offset.
    always_comb begin
        frame_row = ADDR_W'(tile_y_q) * ADDR_W'(80) + ADDR_W'(wh_row);
        addr_calc = frame_row * ROW_STRIDE + ADDR_W'(tile_x_q) * ADDR_W'(20) + ADDR_W'(wh_col);
        mem_addr  = busy_q ? addr_calc : '0;
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign tile_x     = tile_x_q;
    assign tile_y     = tile_y_q;
    assign wh_en      = wh_en_q;
    assign mem_rd     = mem_rd_q;
    assign win_count  = win_count_q;
    assign err        = err_q;
`ifdef SCHED_WDOG_EN
    assign wdog_trip  = wdog_trip_q;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler on a 2x1 tile frame with a behavioural loader,
// a synchronous frame memory and a tile/phase level reference model compared every cycle.
module tb_tile_scheduler;

    localparam int TX  = 2;
    localparam int TY  = 1;
    localparam int NT  = TX * TY;
    localparam int WIN = 4225;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_FILL = 2;
    localparam int P_SCAN = 3;
    localparam int P_NEXT = 4;
    localparam int P_FIN  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wh_ack = 1'b0;
    logic        wh_window_ready = 1'b0;
    logic        wh_done = 1'b0;
    logic [6:0]  wh_row = '0;
    logic [6:0]  wh_col = '0;
    logic        busy, frame_done, wh_en, mem_rd, err;
    logic [0:0]  tile_x, tile_y;
    logic [15:0] mem_addr;
    logic [12:0] win_count;
`ifdef SCHED_WDOG_EN
    logic        wdog_trip;
`endif

    logic [15:0] memArr [0:4095];
    logic [15:0] memData;

    int nChecks = 0;
    int nFails  = 0;

    int mPhase = P_IDLE;
    int mTile  = 0;
    int mWins  = 0;
    bit mErr   = 1'b0;

    int enRises = 0;
    int fdPulses = 0;
    int armTile [0:3];
    bit prevEn = 1'b0;

    tile_scheduler #(
        .TILES_X(TX), .TILES_Y(TY), .ADDR_W(16), .WIN_PER_TILE(WIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .frame_done(frame_done), .tile_x(tile_x), .tile_y(tile_y),
        .wh_en(wh_en), .wh_ack(wh_ack), .wh_row(wh_row), .wh_col(wh_col),
        .wh_window_ready(wh_window_ready), .wh_done(wh_done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .win_count(win_count), .err(err)
`ifdef SCHED_WDOG_EN
        , .wdog_trip(wdog_trip)
`endif
    );

    always #5 clk = ~clk;

    // Frame memory with one-cycle read latency, preloaded with a known pattern.
    initial begin
        for (int i = 0; i < 4096; i++) memArr[i] = 16'(i) ^ 16'hA5A5;
    end

    always @(posedge clk) begin
        if (mem_rd) memData <= memArr[mem_addr[11:0]];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: frame progress kept as a linear tile index and a phase.
    task automatic modelStep();
        if (rst) begin
            mPhase = P_IDLE; mTile = 0; mWins = 0; mErr = 1'b0;
        end else if (abort) begin
            mPhase = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE: if (start) begin
                    mTile = 0; mWins = 0; mErr = 1'b0; mPhase = P_ARM;
                end
                P_ARM: if (wh_ack) mPhase = P_FILL;
                P_FILL: begin
                    if (wh_done) begin
                        mErr = 1'b1; mPhase = P_NEXT;
                    end else if (wh_window_ready) begin
                        mWins = 1; mPhase = P_SCAN;
                    end
                end
                P_SCAN: begin
                    if (wh_window_ready) mWins++;
                    if (wh_done) begin
                        if (mWins != WIN) mErr = 1'b1;
                        mPhase = P_NEXT;
                    end
                end
                P_NEXT: begin
                    mTile++;
                    if (mTile == NT) mPhase = P_FIN;
                    else begin
                        mPhase = P_ARM; mWins = 0;
                    end
                end
                default: mPhase = P_IDLE;
            endcase
        end
    endtask

    task automatic compareAll();
        int ex, ey, ea, ew;
        bit eb;
        eb = (mPhase != P_IDLE);
        ex = mTile % TX;
        ey = mTile / TX;
        if (ey > TY - 1) ey = TY - 1;
        ew = (mWins > 8191) ? 8191 : mWins;
        ea = eb ? (((ey * 80 + int'(wh_row)) * (TX * 20) + ex * 20 + int'(wh_col)) & 32'hFFFF) : 0;
        checkOutput("busy", int'(busy), int'(eb));
        checkOutput("wh_en", int'(wh_en), int'(mPhase == P_ARM));
        checkOutput("mem_rd", int'(mem_rd), int'(mPhase == P_ARM || mPhase == P_FILL));
        checkOutput("frame_done", int'(frame_done), int'(mPhase == P_FIN));
        checkOutput("tile_x", int'(tile_x), ex);
        checkOutput("tile_y", int'(tile_y), ey);
        checkOutput("win_count", int'(win_count), ew);
        checkOutput("err", int'(err), int'(mErr));
        checkOutput("mem_addr", int'(mem_addr), ea);
    endtask

    // Model advances on the same edge as the DUT; outputs are compared just after it.
    always @(posedge clk) begin
        modelStep();
        #1;
        compareAll();
        if (wh_en && !prevEn) begin
            if (enRises < 4) armTile[enRises] = int'(tile_x);
            enRises++;
        end
        prevEn = wh_en;
        if (frame_done) fdPulses++;
    end

    task automatic applyStimulus(input bit st, input bit ab, input bit ack, input bit rdy,
                                 input bit dn, input int r, input int c);
        start = st; abort = ab; wh_ack = ack; wh_window_ready = rdy; wh_done = dn;
        wh_row = 7'(r); wh_col = 7'(c);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic waitEnable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            start = 1'b0; abort = 1'b0; wh_ack = 1'b0; wh_window_ready = 1'b0; wh_done = 1'b0;
            if (wh_en) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checkOutput("wh_en_wait", int'(wh_en), 1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 50; i++) begin
            start = 1'b0; abort = 1'b0; wh_ack = 1'b0; wh_window_ready = 1'b0; wh_done = 1'b0;
            if (!busy) return;
            @(negedge clk);
        end
        checkOutput("idle_wait", int'(busy), 0);
    endtask

    // Behavioural loader: ack, 1600 fill words, then windows with optional gaps.
    task automatic runTile(input int nwin, input int ackDelay, input int gapPct,
                           input bit earlyDone, input bit probe, input int abortAt);
        bit ok;
        waitEnable(ok);
        if (!ok) return;
        idleCycles(ackDelay);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k < 1600; k++) begin
            if (earlyDone && k == 500) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k / 20, k % 20);
                return;
            end
            if (probe && k == 103) begin
                start = 1'b0; wh_row = 7'd5; wh_col = 7'd3;
                #1;
                checkOutput("addr_probe", int'(mem_addr), 223);
                @(posedge clk);
                #2;
                checkOutput("mem_data", int'(memData), 32'hA57A);
                @(negedge clk);
            end else begin
                applyStimulus(k == 10, 1'b0, 1'b0, 1'b0, 1'b0, k / 20, k % 20);
            end
        end
        for (int w = 1; w <= nwin; w++) begin
            while (int'($urandom_range(0, 99)) < gapPct)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            if (abortAt != 0 && w == abortAt + 1) begin
                checkOutput("win_before_abort", int'(win_count), abortAt);
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                checkOutput("abort_busy", int'(busy), 0);
                checkOutput("abort_wh_en", int'(wh_en), 0);
                checkOutput("abort_frame_done", int'(frame_done), 0);
                return;
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, w == nwin,
                          int'($urandom_range(0, 79)), int'($urandom_range(0, 19)));
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_wh_en", int'(wh_en), 0);
        checkOutput("rst_mem_addr", int'(mem_addr), 0);
        checkOutput("rst_err", int'(err), 0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] start+abort together in IDLE");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("start_abort_busy", int'(busy), 0);
        idleCycles(2);

        $display("[TB] clean two-tile frame");
        enRises = 0; fdPulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        runTile(WIN, 1, 0, 1'b0, 1'b0, 0);
        runTile(WIN, 0, 0, 1'b0, 1'b1, 0);
        waitIdle();
        idleCycles(2);
        checkOutput("f1_arm_count", enRises, 2);
        checkOutput("f1_arm_tile0", armTile[0], 0);
        checkOutput("f1_arm_tile1", armTile[1], 1);
        checkOutput("f1_frame_done", fdPulses, 1);
        checkOutput("f1_err", int'(err), 0);

        $display("[TB] short window count sets err");
        fdPulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        runTile(WIN - 1, 2, 0, 1'b0, 1'b0, 0);
        runTile(WIN, 0, 0, 1'b0, 1'b0, 0);
        waitIdle();
        idleCycles(3);
        checkOutput("f2_err_hold", int'(err), 1);
        checkOutput("f2_frame_done", fdPulses, 1);

        $display("[TB] abort in SCAN");
        fdPulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("restart_err_clear", int'(err), 0);
        runTile(WIN, 0, 0, 1'b0, 1'b0, 100);
        idleCycles(3);
        checkOutput("abort_no_done", fdPulses, 0);

        $display("[TB] restart after abort, random frame with early done");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("restart_tile_x", int'(tile_x), 0);
        checkOutput("restart_tile_y", int'(tile_y), 0);
        checkOutput("restart_win", int'(win_count), 0);
        checkOutput("restart_wh_en", int'(wh_en), 1);
        runTile(WIN - 2 + int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 10, 1'b0, 1'b0, 0);
        runTile(WIN, int'($urandom_range(0, 3)), 10, 1'b1, 1'b0, 0);
        waitIdle();
        checkOutput("f3_err", int'(err), 1);

        $display("[TB] reset mid-frame clears err");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        runTile(WIN - 2, 0, 0, 1'b0, 1'b0, 0);
        waitEnable(ok);
        checkOutput("pre_rst_err", int'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_err", int'(err), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] random-gap clean frame");
        fdPulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        runTile(WIN, int'($urandom_range(0, 3)), 15, 1'b0, 1'b0, 0);
        runTile(WIN, int'($urandom_range(0, 3)), 15, 1'b0, 1'b0, 0);
        waitIdle();
        idleCycles(2);
        checkOutput("f5_err", int'(err), 0);
        checkOutput("f5_frame_done", fdPulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
